// File: rtl/pipeline_stall_ctrl.sv
// Purpose : decode-to-fetch/memory sequencer; freezes fetch while a branch or data access is outstanding.
// Latency : issue -> stall next cycle; resolve/ack -> RESUME next cycle (continue/redirect), RUN the cycle after.
// Backpressure: fetch_stall holds PC and IF/ID; decode_bubble feeds NOPs to execute; watchdog bounds every wait.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   issue_valid         decode presents an instruction; branch_d / mem_access_d / mem_write_d classify it
//   branch_resolve      memory stage resolved the branch; branch_taken / branch_target qualify it
//   dmem_ack            data memory finished the outstanding access
//   fetch_stall         high in every non-RUN state
//   decode_bubble       high while waiting on a branch or memory access
//   branch_continue     one-cycle release of decode's branch stall
//   dmem_continue       one-cycle release of decode's memory stall
//   pc_redirect         one-cycle PC load strobe; redirect_pc holds the target (and keeps it afterwards)
//   dmem_req, dmem_we   one-cycle data memory request strobe and its latched write enable
//   timeout_err         sticky watchdog flag
//   stall_cycles        saturating count of cycles with fetch_stall high
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        branch_d,
  input  logic        mem_access_d,
  input  logic        mem_write_d,
  input  logic        branch_resolve,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        dmem_ack,
  output logic        fetch_stall,
  output logic        decode_bubble,
  output logic        branch_continue,
  output logic        dmem_continue,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        timeout_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    RESUME   = 2'd3
  } state_t;

  // The counter holds the number of wait cycles already completed before the
  // current one, so the watchdog fires at the edge closing wait cycle TIMEOUT.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      wd_cnt          <= 8'd0;
      fetch_stall     <= 1'b0;
      decode_bubble   <= 1'b0;
      branch_continue <= 1'b0;
      dmem_continue   <= 1'b0;
      pc_redirect     <= 1'b0;
      redirect_pc     <= 32'd0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      timeout_err     <= 1'b0;
      stall_cycles    <= 32'd0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      branch_continue <= 1'b0;
      dmem_continue   <= 1'b0;
      pc_redirect     <= 1'b0;
      dmem_req        <= 1'b0;

      // Counts the cycle that is ending now, using the registered stall level.
      if (fetch_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end

      case (state)
        RUN: begin
          // Branch wins over memory when decode flags both.
          if (issue_valid && branch_d) begin
            state         <= BR_WAIT;
            wd_cnt        <= 8'd0;
            fetch_stall   <= 1'b1;
            decode_bubble <= 1'b1;
          end else if (issue_valid && mem_access_d) begin
            state         <= MEM_WAIT;
            wd_cnt        <= 8'd0;
            fetch_stall   <= 1'b1;
            decode_bubble <= 1'b1;
            dmem_req      <= 1'b1;
            dmem_we       <= mem_write_d;
          end
        end

        BR_WAIT: begin
          // A resolve on the timeout edge still counts as a normal resolve.
          if (branch_resolve) begin
            state           <= RESUME;
            decode_bubble   <= 1'b0;
            branch_continue <= 1'b1;
            if (branch_taken) begin
              pc_redirect <= 1'b1;
              redirect_pc <= branch_target;
            end
          end else if (wd_cnt == WD_LAST) begin
            state           <= RESUME;
            decode_bubble   <= 1'b0;
            branch_continue <= 1'b1;
            timeout_err     <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end

        MEM_WAIT: begin
          // An ack coinciding with the request strobe lands here too.
          if (dmem_ack) begin
            state         <= RESUME;
            decode_bubble <= 1'b0;
            dmem_continue <= 1'b1;
          end else if (wd_cnt == WD_LAST) begin
            state         <= RESUME;
            decode_bubble <= 1'b0;
            dmem_continue <= 1'b1;
            timeout_err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end

        RESUME: begin
          // Issue is deliberately not sampled here; decode re-presents next cycle.
          state         <= RUN;
          fetch_stall   <= 1'b0;
          decode_bubble <= 1'b0;
        end

        default: begin
          state         <= RUN;
          fetch_stall   <= 1'b0;
          decode_bubble <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int TO = 4;
  localparam int N  = 600;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        branch_d;
  logic        mem_access_d;
  logic        mem_write_d;
  logic        branch_resolve;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dmem_ack;
  logic        fetch_stall;
  logic        decode_bubble;
  logic        branch_continue;
  logic        dmem_continue;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        timeout_err;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Stimulus indexed by the sampling edge; expectations indexed by the cycle after that edge.
  bit        s_iv[N], s_bd[N], s_ma[N], s_mw[N], s_br[N], s_bt[N], s_ack[N];
  bit [31:0] s_tgt[N];
  bit        e_fs[N+1], e_db[N+1], e_bc[N+1], e_dc[N+1], e_pr[N+1];
  bit        e_dreq[N+1], e_dwe[N+1], e_te[N+1], e_rset[N+1];
  bit [31:0] e_rpc[N+1], e_stall[N+1];

  pipeline_stall_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .branch_d(branch_d), .mem_access_d(mem_access_d),
    .mem_write_d(mem_write_d), .branch_resolve(branch_resolve), .branch_taken(branch_taken),
    .branch_target(branch_target), .dmem_ack(dmem_ack),
    .fetch_stall(fetch_stall), .decode_bubble(decode_bubble),
    .branch_continue(branch_continue), .dmem_continue(dmem_continue),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1);
  end

  task automatic clear_inputs();
    issue_valid = 0; branch_d = 0; mem_access_d = 0; mem_write_d = 0;
    branch_resolve = 0; branch_taken = 0; branch_target = 32'h0; dmem_ack = 0;
  endtask

  // Leaves the bench 1 time unit after the last reset edge: next edge is edge 0.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL rst_fetch_stall got %0b exp 0", fetch_stall); end
    checks++; if (decode_bubble !== 1'b0) begin errors++; $display("FAIL rst_decode_bubble got %0b exp 0", decode_bubble); end
    checks++; if ({branch_continue, dmem_continue, pc_redirect, dmem_req, dmem_we, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL rst_pulses got %b exp 000000", {branch_continue, dmem_continue, pc_redirect, dmem_req, dmem_we, timeout_err}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %h exp 0", redirect_pc); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL rst_stall_cycles got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_branch(input bit taken);
    logic [31:0] tgt;
    tgt = 32'h0040_0100;
    do_reset();
    issue_valid = 1; branch_d = 1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      issue_valid = 0; branch_d = 0;
      branch_resolve = (c == 3);
      branch_taken   = (c == 3) && taken;
      branch_target  = (c == 3) ? tgt : 32'hDEAD_BEEF;
      checks++; if (fetch_stall !== (c <= 4)) begin errors++; $display("FAIL br_fetch_stall taken=%0b cycle %0d got %0b exp %0b", taken, c, fetch_stall, (c <= 4)); end
      checks++; if (decode_bubble !== (c <= 3)) begin errors++; $display("FAIL br_decode_bubble taken=%0b cycle %0d got %0b exp %0b", taken, c, decode_bubble, (c <= 3)); end
      checks++; if (branch_continue !== (c == 4)) begin errors++; $display("FAIL br_continue taken=%0b cycle %0d got %0b exp %0b", taken, c, branch_continue, (c == 4)); end
      checks++; if (pc_redirect !== (taken && c == 4)) begin errors++; $display("FAIL br_redirect taken=%0b cycle %0d got %0b exp %0b", taken, c, pc_redirect, (taken && c == 4)); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL br_dmem_req taken=%0b cycle %0d got %0b exp 0", taken, c, dmem_req); end
      if (c >= 4) begin
        checks++; if (redirect_pc !== (taken ? tgt : 32'h0)) begin errors++; $display("FAIL br_redirect_pc taken=%0b cycle %0d got %h exp %h", taken, c, redirect_pc, (taken ? tgt : 32'h0)); end
      end
    end
    clear_inputs();
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL br_stall_cycles taken=%0b got %0d exp 4", taken, stall_cycles); end
  endtask

  task automatic test_store_same_cycle_ack();
    do_reset();
    issue_valid = 1; mem_access_d = 1; mem_write_d = 1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      issue_valid = 0; mem_access_d = 0; mem_write_d = 0;
      dmem_ack = (c == 1);
      checks++; if (dmem_req !== (c == 1)) begin errors++; $display("FAIL st_dmem_req cycle %0d got %0b exp %0b", c, dmem_req, (c == 1)); end
      if (c == 1) begin
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL st_dmem_we cycle %0d got %0b exp 1", c, dmem_we); end
      end
      checks++; if (dmem_continue !== (c == 2)) begin errors++; $display("FAIL st_dmem_continue cycle %0d got %0b exp %0b", c, dmem_continue, (c == 2)); end
      checks++; if (fetch_stall !== (c <= 2)) begin errors++; $display("FAIL st_fetch_stall cycle %0d got %0b exp %0b", c, fetch_stall, (c <= 2)); end
      checks++; if (decode_bubble !== (c == 1)) begin errors++; $display("FAIL st_decode_bubble cycle %0d got %0b exp %0b", c, decode_bubble, (c == 1)); end
    end
    clear_inputs();
    checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL st_stall_cycles got %0d exp 2", stall_cycles); end
  endtask

  // Both flags set; ack noise is ignored; resolve lands on the watchdog edge and must win.
  task automatic test_priority();
    do_reset();
    issue_valid = 1; branch_d = 1; mem_access_d = 1; mem_write_d = 1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      issue_valid = 0; branch_d = 0; mem_access_d = 0; mem_write_d = 0;
      dmem_ack = (c == 1 || c == 2);
      branch_resolve = (c == 4); branch_taken = (c == 4);
      branch_target = 32'h1234_5678;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL pri_dmem_req cycle %0d got %0b exp 0", c, dmem_req); end
      checks++; if (dmem_continue !== 1'b0) begin errors++; $display("FAIL pri_dmem_continue cycle %0d got %0b exp 0", c, dmem_continue); end
      checks++; if (decode_bubble !== (c <= 4)) begin errors++; $display("FAIL pri_decode_bubble cycle %0d got %0b exp %0b", c, decode_bubble, (c <= 4)); end
      checks++; if (branch_continue !== (c == 5)) begin errors++; $display("FAIL pri_branch_continue cycle %0d got %0b exp %0b", c, branch_continue, (c == 5)); end
      checks++; if (pc_redirect !== (c == 5)) begin errors++; $display("FAIL pri_redirect cycle %0d got %0b exp %0b", c, pc_redirect, (c == 5)); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL pri_timeout_err cycle %0d got %0b exp 0", c, timeout_err); end
    end
    clear_inputs();
    checks++; if (redirect_pc !== 32'h1234_5678) begin errors++; $display("FAIL pri_redirect_pc got %h exp 12345678", redirect_pc); end
  endtask

  task automatic test_watchdog();
    do_reset();
    issue_valid = 1; mem_access_d = 1; mem_write_d = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      issue_valid = 0; mem_access_d = 0;
      branch_resolve = (c == 2); branch_taken = (c == 2);
      checks++; if (dmem_req !== (c == 1)) begin errors++; $display("FAIL wd_dmem_req cycle %0d got %0b exp %0b", c, dmem_req, (c == 1)); end
      checks++; if (decode_bubble !== (c <= 4)) begin errors++; $display("FAIL wd_decode_bubble cycle %0d got %0b exp %0b", c, decode_bubble, (c <= 4)); end
      checks++; if (dmem_continue !== (c == 5)) begin errors++; $display("FAIL wd_dmem_continue cycle %0d got %0b exp %0b", c, dmem_continue, (c == 5)); end
      checks++; if (timeout_err !== (c >= 5)) begin errors++; $display("FAIL wd_timeout_err cycle %0d got %0b exp %0b", c, timeout_err, (c >= 5)); end
      checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL wd_redirect cycle %0d got %0b exp 0", c, pc_redirect); end
      checks++; if (fetch_stall !== (c <= 5)) begin errors++; $display("FAIL wd_fetch_stall cycle %0d got %0b exp %0b", c, fetch_stall, (c <= 5)); end
    end
    clear_inputs();
  endtask

  // Enters with timeout_err still set from the watchdog scenario.
  task automatic test_reset_mid();
    issue_valid = 1; branch_d = 1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      clear_inputs();
    end
    checks++; if (decode_bubble !== 1'b1) begin errors++; $display("FAIL rm_in_wait got %0b exp 1", decode_bubble); end
    rst = 1;
    @(posedge clk); #1;
    branch_resolve = 1; branch_taken = 1; branch_target = 32'hCAFE_0000;
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();
    checks++; if ({fetch_stall, decode_bubble, branch_continue, dmem_continue, pc_redirect, dmem_req, dmem_we, timeout_err} !== 8'b0) begin
      errors++; $display("FAIL rm_outputs got %b exp 00000000", {fetch_stall, decode_bubble, branch_continue, dmem_continue, pc_redirect, dmem_req, dmem_we, timeout_err}); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rm_stall_cycles got %0d exp 0", stall_cycles); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL rm_redirect_pc got %h exp 0", redirect_pc); end
    branch_resolve = 1; branch_taken = 1; branch_target = 32'hCAFE_0004;
    @(posedge clk); #1;
    clear_inputs();
    checks++; if ({branch_continue, pc_redirect, fetch_stall} !== 3'b0) begin
      errors++; $display("FAIL rm_late_resolve got %b exp 000", {branch_continue, pc_redirect, fetch_stall}); end
  endtask

  // Transaction-level model: each instruction is an issue edge, a latency and a resolution;
  // the expected waveform is painted from those with arithmetic on cycle indices.
  task automatic build_model();
    int t, kind, lat, w, r;
    bit is_br;
    for (int c = 0; c <= N; c++) begin
      e_fs[c] = 0; e_db[c] = 0; e_bc[c] = 0; e_dc[c] = 0; e_pr[c] = 0;
      e_dreq[c] = 0; e_dwe[c] = 0; e_te[c] = 0; e_rset[c] = 0; e_rpc[c] = 0; e_stall[c] = 0;
    end
    for (int e = 0; e < N; e++) begin
      s_iv[e] = 1'($urandom_range(0, 1)); s_bd[e] = 0; s_ma[e] = 0;
      s_mw[e] = 1'($urandom_range(0, 1)); s_br[e] = 1'($urandom_range(0, 1));
      s_bt[e] = 1'($urandom_range(0, 1)); s_tgt[e] = $urandom; s_ack[e] = 1'($urandom_range(0, 1));
    end
    t = $urandom_range(0, 2);
    while (t + 8 < N) begin
      kind  = $urandom_range(0, 2);
      is_br = (kind != 1);
      lat   = $urandom_range(1, 6);
      w     = (lat > TO) ? TO : lat;
      r     = t + w + 1;
      s_iv[t] = 1; s_bd[t] = is_br; s_ma[t] = (kind != 0);
      for (int e = t + 1; e <= r; e++) begin
        s_iv[e] = 1'($urandom_range(0, 1)); s_bd[e] = 1'($urandom_range(0, 1)); s_ma[e] = 1'($urandom_range(0, 1));
        if (e <= t + w) begin
          if (is_br) s_br[e] = 0; else s_ack[e] = 0;
        end
      end
      if (lat <= TO) begin
        if (is_br) s_br[t + lat] = 1; else s_ack[t + lat] = 1;
      end
      for (int c = t + 1; c <= t + w; c++) begin
        e_fs[c] = 1; e_db[c] = 1;
      end
      e_fs[r] = 1;
      if (is_br) begin
        e_bc[r] = 1;
        if (lat <= TO && s_bt[t + lat]) begin
          e_pr[r] = 1; e_rset[r] = 1; e_rpc[r] = s_tgt[t + lat];
        end
      end else begin
        e_dreq[t + 1] = 1; e_dwe[t + 1] = s_mw[t]; e_dc[r] = 1;
      end
      if (lat > TO) e_te[r] = 1;
      t = r + 1 + $urandom_range(0, 2);
    end
    for (int c = 1; c <= N; c++) begin
      if (!e_rset[c]) e_rpc[c] = e_rpc[c - 1];
      e_te[c]    = e_te[c] | e_te[c - 1];
      e_stall[c] = e_stall[c - 1] + {31'd0, e_fs[c - 1]};
    end
  endtask

  task automatic test_random();
    int c;
    build_model();
    do_reset();
    for (int e = 0; e < N; e++) begin
      issue_valid = s_iv[e]; branch_d = s_bd[e]; mem_access_d = s_ma[e]; mem_write_d = s_mw[e];
      branch_resolve = s_br[e]; branch_taken = s_bt[e]; branch_target = s_tgt[e]; dmem_ack = s_ack[e];
      @(posedge clk); #1;
      c = e + 1;
      checks++; if (fetch_stall !== e_fs[c]) begin errors++; $display("FAIL rnd_fetch_stall cycle %0d got %0b exp %0b", c, fetch_stall, e_fs[c]); end
      checks++; if (decode_bubble !== e_db[c]) begin errors++; $display("FAIL rnd_decode_bubble cycle %0d got %0b exp %0b", c, decode_bubble, e_db[c]); end
      checks++; if (branch_continue !== e_bc[c]) begin errors++; $display("FAIL rnd_branch_continue cycle %0d got %0b exp %0b", c, branch_continue, e_bc[c]); end
      checks++; if (dmem_continue !== e_dc[c]) begin errors++; $display("FAIL rnd_dmem_continue cycle %0d got %0b exp %0b", c, dmem_continue, e_dc[c]); end
      checks++; if (pc_redirect !== e_pr[c]) begin errors++; $display("FAIL rnd_pc_redirect cycle %0d got %0b exp %0b", c, pc_redirect, e_pr[c]); end
      checks++; if (redirect_pc !== e_rpc[c]) begin errors++; $display("FAIL rnd_redirect_pc cycle %0d got %h exp %h", c, redirect_pc, e_rpc[c]); end
      checks++; if (dmem_req !== e_dreq[c]) begin errors++; $display("FAIL rnd_dmem_req cycle %0d got %0b exp %0b", c, dmem_req, e_dreq[c]); end
      if (e_dreq[c]) begin
        checks++; if (dmem_we !== e_dwe[c]) begin errors++; $display("FAIL rnd_dmem_we cycle %0d got %0b exp %0b", c, dmem_we, e_dwe[c]); end
      end
      checks++; if (timeout_err !== e_te[c]) begin errors++; $display("FAIL rnd_timeout_err cycle %0d got %0b exp %0b", c, timeout_err, e_te[c]); end
      checks++; if (stall_cycles !== e_stall[c]) begin errors++; $display("FAIL rnd_stall_cycles cycle %0d got %0d exp %0d", c, stall_cycles, e_stall[c]); end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_branch(1'b1);
    test_branch(1'b0);
    test_store_same_cycle_ack();
    test_priority();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
